// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and narrowing helpers for the matrix multiply engine
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_A   = 3'd1,
    RD_B   = 3'd2,
    WR_C   = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Widest accumulator the narrowing helper can classify
  localparam int LANE_W_MAX = 128;

  localparam logic [1:0] SAT_NONE = 2'b00;
  localparam logic [1:0] SAT_HI   = 2'b01;
  localparam logic [1:0] SAT_LO   = 2'b10;

  // Accumulator width: full product plus headroom for 2^dim_w terms
  function automatic int lane_acc_w(input int data_w, input int dim_w);
    return 2 * data_w + dim_w;
  endfunction

  // Classifies a sign-extended accumulator against the signed data_w range
  function automatic logic [1:0] sat_class(input logic signed [LANE_W_MAX-1:0] v,
                                           input int data_w);
    logic signed [LANE_W_MAX-1:0] one;
    logic signed [LANE_W_MAX-1:0] hi;
    logic signed [LANE_W_MAX-1:0] lo;
    one = {{(LANE_W_MAX-1){1'b0}}, 1'b1};
    hi  = (one <<< (data_w - 1)) - one;
    lo  = -(one <<< (data_w - 1));
    if (v > hi) return SAT_HI;
    if (v < lo) return SAT_LO;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one signed multiply-accumulate lane with narrowed result
module mac_lane
  import matmul_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 80,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] result
);

  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic signed [2*DATA_W-1:0]   prod;
  logic signed [LANE_W_MAX-1:0] wide;
  logic [1:0]                   cls;

  assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  assign wide = {{(LANE_W_MAX-ACC_W){acc_q[ACC_W-1]}}, acc_q};
  assign cls  = sat_class(wide, DATA_W);

  // Next accumulator value: clear wins over accumulate
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  // Narrow to DATA_W: clamp when saturating, otherwise keep the low bits
  always_comb begin
    result = acc_q[DATA_W-1:0];
    if (SATURATE) begin
      if (cls == SAT_HI)      result = {1'b0, {(DATA_W-1){1'b1}}};
      else if (cls == SAT_LO) result = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/matrix_mult_engine.sv
// rtl/matrix_mult_engine.sv - row-major C = A x B engine over a single-port word memory
module matrix_mult_engine
  import matmul_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int PE_COUNT = 4,
  parameter int DIM_W    = 16,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  M,
  input  logic [DIM_W-1:0]  N,
  input  logic [DIM_W-1:0]  P,
  input  logic [ADDR_W-1:0] left_offset,
  input  logic [ADDR_W-1:0] right_offset,
  input  logic [ADDR_W-1:0] result_offset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int ACC_W = lane_acc_w(DATA_W, DIM_W);
  localparam int LW    = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_PE  = ADDR_W'(PE_COUNT);

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  m_q, m_d, n_q, n_d, p_q, p_d;
  logic [DIM_W-1:0]  i_q, i_d, k_q, k_d, j0_q, j0_d;
  logic [LW-1:0]     l_q, l_d;
  logic [ADDR_W-1:0] a_row_q, a_row_d, a_ptr_q, a_ptr_d;
  logic [ADDR_W-1:0] b_blk_q, b_blk_d, b_ptr_q, b_ptr_d, c_ptr_q, c_ptr_d, roff_q, roff_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] a_val_q, a_val_d;
  logic              wait_q, wait_d, req_q, req_d, we_q, we_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, err_pend_q, err_pend_d;
  logic              rd_accept, last_lane, more_blocks, lane_clear, lane_en;
  logic [LW-1:0]     l_nxt;
  logic [DATA_W-1:0] lane_res [PE_COUNT];

  assign l_nxt       = l_q + LW'(1);
  assign rd_accept   = wait_q && mem_rvalid && (state_q == RD_A || state_q == RD_B);
  assign lane_en     = rd_accept && (state_q == RD_B);
  assign last_lane   = (l_q == LW'(PE_COUNT - 1)) ||
                       (({1'b0, j0_q} + (DIM_W+1)'(l_q) + (DIM_W+1)'(1)) >= {1'b0, p_q});
  assign more_blocks = ({1'b0, j0_q} + (DIM_W+1)'(PE_COUNT)) < {1'b0, p_q};

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = we_q ? lane_res[l_q] : '0;

  for (genvar g = 0; g < PE_COUNT; g++) begin : g_lane
    mac_lane #(
      .DATA_W  (DATA_W),
      .ACC_W   (ACC_W),
      .SATURATE(SATURATE != 0)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (lane_clear),
      .en    (lane_en && (l_q == LW'(g))),
      .a     (a_val_q),
      .b     (mem_rdata),
      .result(lane_res[g])
    );
  end

  // Sequencer: walks rows, column blocks and k, moving pointers by addition only
  always_comb begin
    state_d = state_q; m_d = m_q; n_d = n_q; p_d = p_q;
    i_d = i_q; k_d = k_q; j0_d = j0_q; l_d = l_q;
    a_row_d = a_row_q; a_ptr_d = a_ptr_q; b_blk_d = b_blk_q; b_ptr_d = b_ptr_q;
    c_ptr_d = c_ptr_q; roff_d = roff_q; addr_d = addr_q; a_val_d = a_val_q;
    wait_d = wait_q; req_d = req_q; we_d = we_q; busy_d = busy_q;
    done_d = 1'b0; err_d = 1'b0; err_pend_d = err_pend_q; lane_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        lane_clear = 1'b1;
        if (start) begin
          m_d = M; n_d = N; p_d = P;
          i_d = '0; k_d = '0; j0_d = '0; l_d = '0;
          a_row_d = left_offset; a_ptr_d = left_offset;
          b_blk_d = right_offset; b_ptr_d = right_offset; roff_d = right_offset;
          c_ptr_d = result_offset; busy_d = 1'b1; wait_d = 1'b0;
          if (M == '0 || N == '0 || P == '0) begin
            err_pend_d = 1'b1;
            state_d    = FINISH;
          end else begin
            req_d = 1'b1; we_d = 1'b0; addr_d = left_offset;
            state_d = RD_A;
          end
        end
      end
      RD_A: begin
        if (req_q && mem_gnt) begin
          req_d = 1'b0; wait_d = 1'b1;
        end else if (rd_accept) begin
          wait_d = 1'b0; a_val_d = mem_rdata; l_d = '0;
          req_d = 1'b1; addr_d = b_ptr_q; state_d = RD_B;
        end
      end
      RD_B: begin
        if (req_q && mem_gnt) begin
          req_d = 1'b0; wait_d = 1'b1;
        end else if (rd_accept) begin
          wait_d = 1'b0; req_d = 1'b1;
          if (!last_lane) begin
            l_d = l_nxt; addr_d = b_ptr_q + ADDR_W'(l_nxt);
          end else if (k_q == n_q - DIM_W'(1)) begin
            l_d = '0; we_d = 1'b1; addr_d = c_ptr_q; state_d = WR_C;
          end else begin
            k_d = k_q + DIM_W'(1);
            a_ptr_d = a_ptr_q + A_ONE; b_ptr_d = b_ptr_q + ADDR_W'(p_q);
            addr_d = a_ptr_q + A_ONE; state_d = RD_A;
          end
        end
      end
      WR_C: begin
        if (req_q && mem_gnt) begin
          c_ptr_d = c_ptr_q + A_ONE;
          if (!last_lane) begin
            l_d = l_nxt; addr_d = c_ptr_q + A_ONE;
          end else begin
            we_d = 1'b0; lane_clear = 1'b1; k_d = '0; l_d = '0;
            if (more_blocks) begin
              j0_d = j0_q + DIM_W'(PE_COUNT);
              b_blk_d = b_blk_q + A_PE; b_ptr_d = b_blk_q + A_PE;
              a_ptr_d = a_row_q; addr_d = a_row_q; state_d = RD_A;
            end else if (i_q != m_q - DIM_W'(1)) begin
              i_d = i_q + DIM_W'(1); j0_d = '0;
              a_row_d = a_row_q + ADDR_W'(n_q); a_ptr_d = a_row_q + ADDR_W'(n_q);
              b_blk_d = roff_q; b_ptr_d = roff_q;
              addr_d = a_row_q + ADDR_W'(n_q); state_d = RD_A;
            end else begin
              req_d = 1'b0; state_d = FINISH;
            end
          end
        end
      end
      FINISH: begin
        done_d = 1'b1; err_d = err_pend_q; err_pend_d = 1'b0;
        busy_d = 1'b0; state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE; m_q <= '0; n_q <= '0; p_q <= '0;
      i_q <= '0; k_q <= '0; j0_q <= '0; l_q <= '0;
      a_row_q <= '0; a_ptr_q <= '0; b_blk_q <= '0; b_ptr_q <= '0;
      c_ptr_q <= '0; roff_q <= '0; addr_q <= '0; a_val_q <= '0;
      wait_q <= 1'b0; req_q <= 1'b0; we_q <= 1'b0; busy_q <= 1'b0;
      done_q <= 1'b0; err_q <= 1'b0; err_pend_q <= 1'b0;
    end else begin
      state_q <= state_d; m_q <= m_d; n_q <= n_d; p_q <= p_d;
      i_q <= i_d; k_q <= k_d; j0_q <= j0_d; l_q <= l_d;
      a_row_q <= a_row_d; a_ptr_q <= a_ptr_d; b_blk_q <= b_blk_d; b_ptr_q <= b_ptr_d;
      c_ptr_q <= c_ptr_d; roff_q <= roff_d; addr_q <= addr_d; a_val_q <= a_val_d;
      wait_q <= wait_d; req_q <= req_d; we_q <= we_d; busy_q <= busy_d;
      done_q <= done_d; err_q <= err_d; err_pend_q <= err_pend_d;
    end
  end

endmodule

// File: tb/tb_matrix_mult_engine.sv
// tb/tb_matrix_mult_engine.sv - directed bench for matrix_mult_engine
module tb_matrix_mult_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start8 = 1'b0;
  logic [15:0] dim_m = '0, dim_n = '0, dim_p = '0;
  logic [31:0] loff = '0, roff = '0, coff = '0;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_chk = 0, n_fail = 0;
  int n_rd = 0, n_wr = 0, viol = 0, done_cnt = 0, err_cnt = 0;
  bit stall = 1'b0;
  logic [31:0] mem [0:1023];
  logic [31:0] wr_log [$];
  int a_v [0:63];
  int b_v [0:63];

  always #5 clk = ~clk;

  matrix_mult_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .M(dim_m), .N(dim_n), .P(dim_p),
    .left_offset(loff), .right_offset(roff), .result_offset(coff),
    .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // 8-bit engines, saturating and wrapping; every operand read returns 127
  logic s8_busy, s8_done, s8_err, s8_req, s8_we, w8_busy, w8_done, w8_err, w8_req, w8_we;
  logic [31:0] s8_addr, w8_addr;
  logic [7:0]  s8_wdata, w8_wdata, s8_last = '0, w8_last = '0;
  logic        s8_acc = 1'b0, w8_acc = 1'b0;
  int          s8_nwr = 0, w8_nwr = 0;
  logic [7:0]  rd127 = 8'd127;

  matrix_mult_engine #(.DATA_W(8), .SATURATE(1)) dut_s8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .M(dim_m), .N(dim_n), .P(dim_p),
    .left_offset(loff), .right_offset(roff), .result_offset(coff),
    .busy(s8_busy), .done(s8_done), .err(s8_err), .mem_req(s8_req), .mem_we(s8_we),
    .mem_addr(s8_addr), .mem_wdata(s8_wdata), .mem_gnt(s8_req),
    .mem_rvalid(s8_acc), .mem_rdata(rd127)
  );

  matrix_mult_engine #(.DATA_W(8), .SATURATE(0)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .M(dim_m), .N(dim_n), .P(dim_p),
    .left_offset(loff), .right_offset(roff), .result_offset(coff),
    .busy(w8_busy), .done(w8_done), .err(w8_err), .mem_req(w8_req), .mem_we(w8_we),
    .mem_addr(w8_addr), .mem_wdata(w8_wdata), .mem_gnt(w8_req),
    .mem_rvalid(w8_acc), .mem_rdata(rd127)
  );

  always @(posedge clk) begin
    s8_acc <= s8_req & ~s8_we;
    w8_acc <= w8_req & ~w8_we;
    if (s8_req & s8_we) begin s8_last <= s8_wdata; s8_nwr <= s8_nwr + 1; end
    if (w8_req & w8_we) begin w8_last <= w8_wdata; w8_nwr <= w8_nwr + 1; end
  end

  // Memory model for the main engine, driven on the falling edge
  logic        acc_we = 1'b0, prev_req = 1'b0, prev_we = 1'b0;
  logic [31:0] acc_addr = '0, acc_wdata = '0, prev_addr = '0, prev_wdata = '0, pend_addr = '0;
  int          pend = 0, pend_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; pend = 0; prev_req = 1'b0;
    end else begin
      if (mem_gnt) begin
        if (acc_we) begin
          mem[acc_addr[9:0]] = acc_wdata; wr_log.push_back(acc_addr); n_wr++;
        end else begin
          pend = 1; pend_addr = acc_addr; pend_cnt = stall ? $urandom_range(0, 5) : 0; n_rd++;
        end
      end
      if (prev_req && !mem_gnt &&
          {mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, prev_we, prev_addr, prev_wdata})
        viol++;
      mem_rvalid = 1'b0;
      if (pend != 0) begin
        if (pend_cnt == 0) begin
          mem_rvalid = 1'b1; mem_rdata = mem[pend_addr[9:0]]; pend = 0;
        end else begin
          pend_cnt--;
        end
      end
      if (mem_req && (pend != 0 || mem_rvalid)) viol++;
      mem_gnt = mem_req && (stall ? ($urandom_range(0, 99) < 30) : 1'b1);
      if (mem_gnt) begin acc_we = mem_we; acc_addr = mem_addr; acc_wdata = mem_wdata; end
      prev_req = mem_req; prev_we = mem_we; prev_addr = mem_addr; prev_wdata = mem_wdata;
      if (done) done_cnt++;
      if (done && err) err_cnt++;
    end
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_rd = 0; n_wr = 0; viol = 0; done_cnt = 0; err_cnt = 0; wr_log.delete();
  endtask

  task automatic load(input int m, input int n, input int p);
    for (int x = 0; x < m * n; x++) mem[10'h100 + x] = a_v[x];
    for (int x = 0; x < n * p; x++) mem[10'h200 + x] = b_v[x];
    for (int x = 0; x < 64; x++) mem[10'h300 + x] = 32'hDEAD_BEEF;
  endtask

  function automatic logic [31:0] ref_c(input int i, input int j, input int n, input int p);
    longint acc = 0;
    for (int k = 0; k < n; k++) acc += longint'(a_v[i*n+k]) * longint'(b_v[k*p+j]);
    if (acc > 64'sd2147483647) acc = 64'sd2147483647;
    if (acc < -64'sd2147483648) acc = -64'sd2147483648;
    return acc[31:0];
  endfunction

  task automatic run_op(input int m, input int n, input int p, input bit stl);
    int cyc;
    clear_counts(); stall = stl;
    @(negedge clk);
    dim_m = 16'(m); dim_n = 16'(n); dim_p = 16'(p);
    loff = 32'h100; roff = 32'h200; coff = 32'h300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin @(negedge clk); cyc++; end
    chk_eq("done_timeout", 64'(cyc < 20000), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_result(input string tag, input int m, input int n, input int p);
    int bad_order;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < p; j++)
        chk_eq(tag, 64'(mem[10'h300 + i*p + j]), 64'(ref_c(i, j, n, p)));
    bad_order = 0;
    foreach (wr_log[w]) if (wr_log[w] != 32'h300 + 32'(w)) bad_order++;
    chk_eq({tag, "_wr_cnt"}, 64'(n_wr), 64'(m * p));
    chk_eq({tag, "_wr_addr"}, 64'(bad_order), 64'd0);
    chk_eq({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk_eq({tag, "_err"}, 64'(err_cnt), 64'd0);
    chk_eq({tag, "_handshake"}, 64'(viol), 64'd0);
    chk_eq({tag, "_guard"}, 64'(mem[10'h300 + m*p]), 64'hDEAD_BEEF);
  endtask

  initial begin
    int cyc;
    #3;
    chk_eq("rst_ctrl", 64'({busy, done, err, mem_req, mem_we}), 64'd0);
    chk_eq("rst_addr", 64'(mem_addr), 64'd0);
    chk_eq("rst_wdata", 64'(mem_wdata), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Identity
    a_v[0] = 1; a_v[1] = 2; a_v[2] = 3; a_v[3] = 4;
    b_v[0] = 1; b_v[1] = 0; b_v[2] = 0; b_v[3] = 1;
    load(2, 2, 2);
    run_op(2, 2, 2, 1'b0);
    chk_eq("id_c00", 64'(mem[10'h300]), 64'd1);
    chk_eq("id_c11", 64'(mem[10'h303]), 64'd4);
    chk_eq("id_rd_cnt", 64'(n_rd), 64'd12);
    check_result("id", 2, 2, 2);

    // Tail lanes, no stall then stalled
    for (int x = 0; x < 64; x++) begin
      a_v[x] = int'($urandom_range(0, 200)) - 100;
      b_v[x] = int'($urandom_range(0, 200)) - 100;
    end
    load(3, 5, 6);
    run_op(3, 5, 6, 1'b0);
    chk_eq("tail_rd_cnt", 64'(n_rd), 64'd120);
    check_result("tail", 3, 5, 6);
    load(3, 5, 6);
    run_op(3, 5, 6, 1'b1);
    chk_eq("stall_rd_cnt", 64'(n_rd), 64'd120);
    check_result("stall", 3, 5, 6);
    stall = 1'b0;

    // Zero dimension, with start held into the FINISH cycle
    clear_counts();
    @(negedge clk);
    dim_m = 16'd2; dim_n = 16'd0; dim_p = 16'd2; start = 1'b1;
    @(negedge clk);
    chk_eq("zero_busy", 64'({busy, done, mem_req}), 64'b100);
    @(negedge clk);
    start = 1'b0;
    chk_eq("zero_done", 64'({done, err, busy, mem_req}), 64'b1100);
    @(negedge clk);
    chk_eq("zero_after", 64'({done, busy}), 64'b00);
    chk_eq("zero_no_mem", 64'(n_rd + n_wr), 64'd0);

    // Saturation versus wrap on 8-bit engines
    @(negedge clk);
    dim_m = 16'd1; dim_n = 16'd2; dim_p = 16'd1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0;
    while (!s8_done && cyc < 200) begin @(negedge clk); cyc++; end
    chk_eq("sat_timeout", 64'(cyc < 200), 64'd1);
    chk_eq("sat_value", 64'(s8_last), 64'h7F);
    chk_eq("wrap_value", 64'(w8_last), 64'h02);
    chk_eq("sat_wr_cnt", 64'(s8_nwr + w8_nwr), 64'd2);

    // Reset in the middle of RD_B, then a clean rerun
    a_v[0] = 1; a_v[1] = 2; a_v[2] = 3; a_v[3] = 4;
    b_v[0] = 1; b_v[1] = 0; b_v[2] = 0; b_v[3] = 1;
    load(2, 2, 2);
    clear_counts();
    @(negedge clk);
    dim_m = 16'd2; dim_n = 16'd2; dim_p = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(mem_req && !mem_we && mem_addr[31:8] == 24'h2) && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    chk_eq("rst_reach_rdb", 64'(cyc < 200), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("rst_req_drop", 64'({mem_req, busy}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_eq("rst_no_done", 64'(done_cnt), 64'd0);
    run_op(2, 2, 2, 1'b0);
    check_result("rerun", 2, 2, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
